// File: rtl/uart_banner_echo.sv
`timescale 1ns/1ps
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Module   : uart_banner_echo                                                 |
// | Purpose  : streams a ROM banner to the UART TX, then echoes buffered RX     |
// |            bytes plus ECHO_OFFSET. Optional macro: CRLF_EXPAND_EN (CR->LF). |
// | Revision : 1.0                                                              |
// +-----------------------------------------------------------------------------+
module uart_banner_echo #(
   parameter int DATA_W       = 8,
   parameter int ADDR_W       = 8,
   parameter int MSG_LEN      = 192,
   parameter int READY_CYCLES = 8,
   parameter int FIFO_DEPTH   = 4,
   parameter int ECHO_OFFSET  = 1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              rx_done_tick,
   input  logic [DATA_W-1:0] r_data,
   input  logic              tx_ready,
   output logic              tx_start,
   output logic [DATA_W-1:0] w_data,
   output logic [ADDR_W-1:0] rom_addr,
   input  logic [DATA_W-1:0] rom_data,
   input  logic              replay_banner,
   output logic              busy,
   output logic              overflow
);

   localparam int c_rc_w  = $clog2(READY_CYCLES);
   localparam int c_ptr_w = $clog2(FIFO_DEPTH);
   localparam int c_cnt_w = c_ptr_w + 1;
   localparam logic [c_rc_w-1:0]  c_rc_max   = c_rc_w'(READY_CYCLES - 1);
   localparam logic [ADDR_W-1:0]  c_last     = ADDR_W'(MSG_LEN - 1);
   localparam logic [c_cnt_w-1:0] c_full_cnt = c_cnt_w'(FIFO_DEPTH);

   typedef enum logic [0:0] {ST_BANNER = 1'b0, ST_ECHO = 1'b1} state_t;

   state_t              r_state;
   logic [c_rc_w-1:0]   r_ready_cnt;
   logic                r_replay_pend;
   logic [DATA_W-1:0]   r_mem [FIFO_DEPTH];
   logic [c_ptr_w-1:0]  r_wr_ptr;
   logic [c_ptr_w-1:0]  r_rd_ptr;
   logic [c_cnt_w-1:0]  r_count;

   logic                w_go;
   logic                w_empty;
   logic                w_full;
   logic                w_replay;
   logic                w_send_banner;
   logic                w_send_lf;
   logic                w_pop;
   logic                w_push;
   logic                w_send;
   logic                w_crlf_pend;
   logic [DATA_W-1:0]   w_head;

   assign w_go    = tx_ready & (r_ready_cnt == c_rc_max);
   assign w_empty = (r_count == '0);
   assign w_full  = (r_count == c_full_cnt);
   assign w_head  = r_mem[r_rd_ptr];

   // A pending replay wins over an echo on the same cycle so the banner restarts cleanly.
   assign w_replay      = (r_state == ST_ECHO) & r_replay_pend & ~tx_start;
   assign w_send_banner = (r_state == ST_BANNER) & w_go;
   assign w_send_lf     = (r_state == ST_ECHO) & w_go & ~w_replay & w_crlf_pend;
   assign w_pop         = (r_state == ST_ECHO) & w_go & ~w_replay & ~w_crlf_pend & ~w_empty;
   assign w_send        = w_send_banner | w_send_lf | w_pop;
   assign w_push        = rx_done_tick & (~w_full | w_pop);

`ifdef CRLF_EXPAND_EN
   logic r_crlf_pend;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_crlf_pend <= 1'b0;
      end else if (w_send_lf) begin
         r_crlf_pend <= 1'b0;
      end else if (w_pop && (w_head == DATA_W'(8'h0D))) begin
         r_crlf_pend <= 1'b1;
      end
   end

   assign w_crlf_pend = r_crlf_pend;
`else
   assign w_crlf_pend = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem[r_wr_ptr] <= r_data;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + c_ptr_w'(1);
         if (w_pop)  r_rd_ptr <= r_rd_ptr + c_ptr_w'(1);
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + c_cnt_w'(1);
            2'b01:   r_count <= r_count - c_cnt_w'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state       <= ST_BANNER;
         rom_addr      <= '0;
         tx_start      <= 1'b0;
         w_data        <= '0;
         busy          <= 1'b1;
         overflow      <= 1'b0;
         r_ready_cnt   <= '0;
         r_replay_pend <= 1'b0;
      end else begin
         tx_start <= w_send;

         if (w_send_banner)  w_data <= rom_data;
         else if (w_send_lf) w_data <= DATA_W'(8'h0A);
         else if (w_pop)     w_data <= w_head + DATA_W'(ECHO_OFFSET);

         if (rx_done_tick && w_full && !w_pop) overflow <= 1'b1;

         // Counter restarts after each send so strobes are never back to back.
         if (!tx_ready || w_send || tx_start)  r_ready_cnt <= '0;
         else if (r_ready_cnt != c_rc_max)     r_ready_cnt <= r_ready_cnt + c_rc_w'(1);

         if (w_send_banner) begin
            if (rom_addr == c_last) begin
               rom_addr <= '0;
               busy     <= 1'b0;
               r_state  <= ST_ECHO;
            end else begin
               rom_addr <= rom_addr + ADDR_W'(1);
            end
         end else if (w_replay) begin
            rom_addr <= '0;
            busy     <= 1'b1;
            r_state  <= ST_BANNER;
         end

         if (w_replay)                               r_replay_pend <= 1'b0;
         else if (replay_banner && r_state == ST_ECHO) r_replay_pend <= 1'b1;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_uart_banner_echo.sv
`timescale 1ns/1ps
`default_nettype none
// Bench for uart_banner_echo: cycle-level queue model, directed scenarios and random traffic.
module tb_uart_banner_echo;

   localparam int DATA_W       = 8;
   localparam int ADDR_W       = 8;
   localparam int MSG_LEN      = 4;
   localparam int READY_CYCLES = 8;
   localparam int FIFO_DEPTH   = 4;
   localparam int ECHO_OFFSET  = 1;

   logic              clk = 1'b0;
   logic              reset = 1'b1;
   logic              rx_done_tick = 1'b0;
   logic [DATA_W-1:0] r_data = '0;
   logic              tx_ready = 1'b1;
   logic              tx_start;
   logic [DATA_W-1:0] w_data;
   logic [ADDR_W-1:0] rom_addr;
   logic [DATA_W-1:0] rom_data = '0;
   logic              replay_banner = 1'b0;
   logic              busy;
   logic              overflow;

   uart_banner_echo #(
      .DATA_W(DATA_W), .ADDR_W(ADDR_W), .MSG_LEN(MSG_LEN),
      .READY_CYCLES(READY_CYCLES), .FIFO_DEPTH(FIFO_DEPTH), .ECHO_OFFSET(ECHO_OFFSET)
   ) dut (
      .clk(clk), .reset(reset), .rx_done_tick(rx_done_tick), .r_data(r_data),
      .tx_ready(tx_ready), .tx_start(tx_start), .w_data(w_data), .rom_addr(rom_addr),
      .rom_data(rom_data), .replay_banner(replay_banner), .busy(busy), .overflow(overflow)
   );

   always #5 clk = ~clk;

   logic [7:0] rom [0:255];
   initial begin
      for (int i = 0; i < 256; i++) rom[i] = 8'(i * 7 + 3);
      rom[0] = 8'h53; rom[1] = 8'h52; rom[2] = 8'h41; rom[3] = 8'h4D;
   end
   always @(posedge clk) rom_data <= rom[rom_addr];

   int n_vec = 0;
   int n_err = 0;
   int cyc   = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Behavioural model: FIFO as a queue, banner as an index, pacing as a ready streak.
   logic [7:0] q[$];
   bit         m_banner, m_busy, m_ovf, m_tx, m_rpend, m_lf;
   int         m_addr, m_streak;
   logic [7:0] m_wd;

   task automatic model_reset();
      q.delete();
      m_banner = 1; m_busy = 1; m_ovf = 0; m_tx = 0; m_rpend = 0; m_lf = 0;
      m_addr = 0; m_streak = 0; m_wd = 8'h00;
   endtask

   task automatic model_step();
      bit go, rep, snd, was_banner;
      logic [7:0] b;
      was_banner = m_banner;
      go  = tx_ready && (m_streak >= READY_CYCLES - 1);
      rep = !m_banner && m_rpend && !m_tx;
      snd = 0;
      if (m_banner) begin
         if (go) begin
            snd  = 1;
            m_wd = rom[m_addr];
            if (m_addr == MSG_LEN - 1) begin
               m_addr = 0; m_banner = 0; m_busy = 0;
            end else begin
               m_addr++;
            end
         end
      end else if (go && !rep) begin
         if (m_lf) begin
            snd = 1; m_wd = 8'h0A; m_lf = 0;
         end else if (q.size() > 0) begin
            b    = q.pop_front();
            snd  = 1;
            m_wd = b + 8'(ECHO_OFFSET);
`ifdef CRLF_EXPAND_EN
            if (b == 8'h0D) m_lf = 1;
`endif
         end
      end
      if (rx_done_tick) begin
         if (q.size() < FIFO_DEPTH) q.push_back(r_data);
         else m_ovf = 1;
      end
      if (rep) begin
         m_banner = 1; m_addr = 0; m_busy = 1; m_rpend = 0;
      end else if (replay_banner && !was_banner) begin
         m_rpend = 1;
      end
      m_streak = (!tx_ready || snd || m_tx) ? 0 : m_streak + 1;
      m_tx = snd;
   endtask

   initial begin
      model_reset();
      forever begin
         @(posedge clk or posedge reset);
         if (reset) model_reset();
         else model_step();
      end
   end

   typedef struct {logic [7:0] d; int cyc; logic busy;} tx_t;
   tx_t txlog[$];

   initial forever begin
      @(posedge clk);
      #2;
      cyc++;
      if (!reset) begin
         chk("tx_start", tx_start, m_tx);
         chk("w_data",   w_data,   m_wd);
         chk("busy",     busy,     m_busy);
         chk("overflow", overflow, m_ovf);
         chk("rom_addr", rom_addr, 32'(m_addr));
         if (tx_start) txlog.push_back('{d: w_data, cyc: cyc, busy: busy});
      end
   end

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic rx(input logic [7:0] b);
      r_data = b; rx_done_tick = 1'b1;
      @(negedge clk);
      rx_done_tick = 1'b0;
   endtask

   task automatic wait_tx(input int n, input int budget);
      int k = 0;
      while (txlog.size() < n && k < budget) begin
         @(negedge clk);
         k++;
      end
      chk("tx_count_reached", 32'(txlog.size() >= n), 1);
   endtask

   int base;

   initial begin
      // Reset values
      @(negedge clk);
      chk("rst_tx_start", tx_start, 0);
      chk("rst_w_data",   w_data,   0);
      chk("rst_busy",     busy,     1);
      chk("rst_overflow", overflow, 0);
      chk("rst_rom_addr", rom_addr, 0);
      reset = 1'b0;

      // Banner pacing with RX bytes arriving mid-banner
      tick(3);
      rx(8'h31);
      tick(2);
      chk("busy_mid_banner", busy, 1);
      rx(8'h32);
      wait_tx(6, 200);
      chk("banner0", txlog[0].d, 8'h53);
      chk("banner1", txlog[1].d, 8'h52);
      chk("banner2", txlog[2].d, 8'h41);
      chk("banner3", txlog[3].d, 8'h4D);
      for (int i = 1; i < 4; i++)
         chk("banner_gap", 32'(txlog[i].cyc - txlog[i-1].cyc), READY_CYCLES + 1);
      chk("busy_at_3rd", txlog[2].busy, 1);
      chk("busy_at_4th", txlog[3].busy, 0);
      chk("echo_rx0", txlog[4].d, 8'h32);
      chk("echo_rx1", txlog[5].d, 8'h33);
      chk("ovf_after_banner", overflow, 0);

      // Plain echo and offset wrap
      rx(8'h41);
      wait_tx(7, 100);
      chk("echo_41", txlog[6].d, 8'h42);
      rx(8'hFF);
      wait_tx(8, 100);
      chk("echo_ff_wrap", txlog[7].d, 8'h00);
      tick(20);
      chk("single_tx_each", txlog.size(), 8);

      // Overflow with transmitter stalled
      tx_ready = 1'b0;
      base = txlog.size();
      for (int i = 0; i < 5; i++) rx(8'(8'h10 + i));
      tick(1);
      chk("ovf_set", overflow, 1);
      tx_ready = 1'b1;
      wait_tx(base + 4, 200);
      tick(60);
      chk("ovf_tx_count", txlog.size(), base + 4);
      for (int i = 0; i < 4; i++) chk("ovf_echo", txlog[base + i].d, 8'(8'h11 + i));

      // Replay from ECHO
      base = txlog.size();
      replay_banner = 1'b1;
      @(negedge clk);
      replay_banner = 1'b0;
      tick(2);
      chk("replay_busy", busy, 1);
      wait_tx(base + 4, 200);
      chk("replay0", txlog[base].d,     8'h53);
      chk("replay3", txlog[base + 3].d, 8'h4D);
      tick(2);
      chk("replay_done_busy", busy, 0);

      // Async reset in the middle of a banner
      tick(20);
      replay_banner = 1'b1;
      @(negedge clk);
      replay_banner = 1'b0;
      base = txlog.size();
      wait_tx(base + 2, 100);
      chk("pre_reset_char", txlog[base + 1].d, 8'h52);
      chk("pre_reset_tx", tx_start, 1);
      #1 reset = 1'b1;
      #1;
      chk("async_rst_tx_start", tx_start, 0);
      chk("async_rst_rom_addr", rom_addr, 0);
      chk("async_rst_ovf", overflow, 0);
      @(negedge clk);
      reset = 1'b0;
      base = txlog.size();
      wait_tx(base + 4, 200);
      chk("restart_char", txlog[base].d, 8'h53);
      tick(20);

      // Full FIFO with push and pop on the same edge
      tx_ready = 1'b0;
      for (int i = 0; i < 4; i++) rx(8'(8'h20 + i));
      base = txlog.size();
      tx_ready = 1'b1;
      repeat (READY_CYCLES - 1) @(negedge clk);
      rx(8'h24);
      chk("push_pop_full_ovf", overflow, 0);
      wait_tx(base + 5, 200);
      chk("push_pop_first", txlog[base].d,     8'h21);
      chk("push_pop_last",  txlog[base + 4].d, 8'h25);

      // Random traffic
      for (int i = 0; i < 2500; i++) begin
         tx_ready      = ($urandom_range(0, 9) != 0);
         rx_done_tick  = ($urandom_range(0, 11) == 0);
         r_data        = ($urandom_range(0, 7) == 0) ? 8'h0D : 8'($urandom);
         replay_banner = ($urandom_range(0, 299) == 0);
         @(negedge clk);
      end
      tx_ready = 1'b1; rx_done_tick = 1'b0; replay_banner = 1'b0;
      tick(300);

      // Carriage-return handling
      base = txlog.size();
      rx(8'h0D);
      wait_tx(base + 1, 100);
      tick(40);
      chk("cr_echo", txlog[base].d, 8'h0E);
`ifdef CRLF_EXPAND_EN
      chk("cr_tx_count", txlog.size(), base + 2);
      chk("cr_lf", txlog[base + 1].d, 8'h0A);
`else
      chk("cr_tx_count", txlog.size(), base + 1);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/uart_banner_echo.md
Name: uart_banner_echo

Overview:
- Parametrised successor to the UART banner/echo checker.
- Streams a banner of MSG_LEN characters from an external synchronous message ROM to the UART transmitter, then echoes received bytes with a configurable offset.
- Received bytes are buffered in an RX FIFO, so characters arriving during the banner or while TX is busy are not lost.
- Sits between uart_rx/uart_tx and a message ROM on the SRAM-tester console path.

Parameters:
- DATA_W, 8, character width in bits.
- ADDR_W, 8, message ROM address width.
- MSG_LEN, 192, number of banner characters; legal range 1..2^ADDR_W.
- READY_CYCLES, 8, consecutive tx_ready-high cycles required before each tx_start; minimum 2.
- FIFO_DEPTH, 4, RX FIFO entries; power of 2, minimum 2.
- ECHO_OFFSET, 1, value added to each echoed byte, modulo 2^DATA_W.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- rx_done_tick  in  1  one-cycle strobe: r_data is valid
- r_data  in  DATA_W  received byte
- tx_ready  in  1  transmitter idle
- tx_start  out  1  one-cycle transmit strobe
- w_data  out  DATA_W  byte to transmit; valid when tx_start=1
- rom_addr  out  ADDR_W  message ROM address
- rom_data  in  DATA_W  ROM output, 1-cycle read latency
- replay_banner  in  1  pulse: resend the banner
- busy  out  1  high while the banner is being sent
- overflow  out  1  sticky: an RX byte was dropped

Behaviour:
- Reset is asynchronous, active-high; clock is clk.
- Reset values:
  - state=BANNER, rom_addr=0, tx_start=0, w_data=0, busy=1, overflow=0.
  - FIFO empty, ready_cnt=0, replay_pend=0.
- ready_cnt:
  - Counts consecutive cycles with tx_ready=1, saturating at READY_CYCLES-1.
  - Cleared when tx_ready=0 and in the cycle after any tx_start.
  - Define go = tx_ready & (ready_cnt==READY_CYCLES-1).
- tx_start is high for exactly one cycle per character and never on two consecutive cycles.
- BANNER state:
  - rom_addr is held stable between sends, so rom_data is valid at go.
  - On go: tx_start=1, w_data=rom_data, rom_addr+1.
  - If the sent address was MSG_LEN-1: rom_addr<=0, busy<=0, state<=ECHO in the same edge.
- ECHO state:
  - On go with FIFO non-empty: pop head, w_data=head+ECHO_OFFSET (truncated to DATA_W), tx_start=1.
  - Empty FIFO: no action; ready_cnt stays saturated.
- RX FIFO:
  - Push r_data on rx_done_tick in any state; bytes arriving during the banner are echoed afterwards.
  - Push while full with no same-cycle pop: byte dropped, overflow<=1.
  - Push and pop in the same cycle while full: both occur, no overflow.
  - Pointers wrap modulo FIFO_DEPTH.
- overflow is cleared only by reset.
- replay_banner:
  - A pulse sets replay_pend.
  - In ECHO, on a cycle without tx_start and with replay_pend=1: state<=BANNER, rom_addr<=0, busy<=1, replay_pend<=0.
  - Pulses during BANNER are ignored (not latched).
  - FIFO contents are preserved across a replay.
- Reset mid-operation: all state returns to reset values, the FIFO is flushed, and the banner restarts from address 0.

Optional Feature:
- CRLF_EXPAND_EN defined: when a popped raw byte equals 8'h0D, the next transmission in ECHO is 8'h0A, sent without offset and under normal go gating, before any further pop.
- Not defined: no expansion; each popped byte produces exactly one transmission.

Test Plan:
- Banner pacing: MSG_LEN=4, ROM={"S","R","A","M"}, tx_ready held high.
  - Required: tx_start pulses carry 0x53,0x52,0x41,0x4D, spaced READY_CYCLES+1 cycles apart.
  - busy falls with the 4th pulse.
- Echo: after the banner, rx 0x41 -> single tx_start with w_data 0x42. With ECHO_OFFSET=1, rx 0xFF -> 0x00 (wrap).
- RX during banner: rx 0x31,0x32 while busy=1 -> after the last banner character, echoes 0x32,0x33 in order, overflow=0.
- Overflow: FIFO_DEPTH=4, tx_ready=0, 5 rx bytes 0x10..0x14 -> overflow=1.
  - After tx_ready=1: echoes 0x11,0x12,0x13,0x14 only.
  - Full with simultaneous push+pop: no overflow.
- Replay and reset:
  - replay_banner pulse in ECHO -> banner resent from rom_addr=0, busy=1.
  - Async reset mid-banner at character 2 -> tx_start=0 immediately; restart from 0x53.
- CRLF_EXPAND_EN: rx 0x0D -> transmissions 0x0E then 0x0A. With the macro undefined -> 0x0E only.
